// File: rtl/alu_ctrl_fsm_if.sv
// Control-unit bundle: instruction fields and ALU zero flag in, datapath controls out.
// The control FSM is the master; the datapath side is the slave.
interface alu_ctrl_fsm_if #(
    parameter int STATE_W = 4
);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic               RegWrite;
    logic [1:0]         ImmSrc;
    logic [2:0]         AluControl;
    logic [STATE_W-1:0] state;

    modport master (
        input  op, funct3, funct7b5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, AluControl, state
    );

    modport slave (
        output op, funct3, funct7b5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ImmSrc, AluControl, state
    );
endinterface

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle RISC-V control FSM: sequences each instruction and drives the
// ALU operand selects, AluControl code and the datapath enables.
module alu_ctrl_fsm #(
    parameter int STATE_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    alu_ctrl_fsm_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0]         r_state;
    logic [3:0]         w_next;
    logic               w_ir_write;
    logic               w_adr_src;
    logic               w_mem_write;
    logic               w_reg_write;
    logic               w_pc_update;
    logic               w_branch;
    logic [1:0]         w_result_src;
    logic [1:0]         w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [1:0]         w_alu_op;
    logic [1:0]         w_imm_src;
    logic [STATE_W-1:0] w_state_ext;

    // addi never subtracts: only R-type (op[5]=1) honours funct7b5
    function automatic logic [2:0] f_alu_control(input logic [1:0] alu_op,
                                                 input logic [2:0] f3,
                                                 input logic       op5,
                                                 input logic       f7b5);
        logic [2:0] code;
        code = 3'b000;
        case (alu_op)
            2'b00: code = 3'b000;
            2'b01: code = 3'b001;
            2'b10: begin
                case (f3)
                    3'b000:  code = (op5 & f7b5) ? 3'b001 : 3'b000;
                    3'b010:  code = 3'b101;
                    3'b110:  code = 3'b011;
                    3'b111:  code = 3'b010;
                    default: code = 3'b000;
                endcase
            end
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // State register with asynchronous return to FETCH
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state selection
    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECUTER;
                    OP_I:         w_next = S_EXECUTEI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (bus.op == OP_SW) begin
                    w_next = S_MEMWRITE;
                end else if (bus.op == OP_LW) begin
                    w_next = S_MEMREAD;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEMREAD:  w_next = S_MEMWB;
            S_EXECUTER: w_next = S_ALUWB;
            S_EXECUTEI: w_next = S_ALUWB;
            S_JAL:      w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Per-state control decode
    always_comb begin
        w_ir_write   = 1'b0;
        w_adr_src    = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_result_src = 2'b00;
        w_alu_src_a  = 2'b00;
        w_alu_src_b  = 2'b00;
        w_alu_op     = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write   = 1'b1;
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_pc_update  = 1'b1;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
            end
            S_MEMREAD: w_adr_src = 1'b1;
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECUTER: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_alu_op    = 2'b10;
            end
            S_ALUWB: w_reg_write = 1'b1;
            S_BEQ: begin
                w_alu_src_a = 2'b10;
                w_alu_op    = 2'b01;
                w_branch    = 1'b1;
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_pc_update = 1'b1;
            end
            default: w_ir_write = 1'b0;
        endcase
    end

    // Immediate format follows the opcode alone
    always_comb begin
        w_imm_src = 2'b00;
        case (bus.op)
            OP_SW:   w_imm_src = 2'b01;
            OP_BEQ:  w_imm_src = 2'b10;
            OP_JAL:  w_imm_src = 2'b11;
            default: w_imm_src = 2'b00;
        endcase
    end

    // Debug state, zero-extended to the bus width
    always_comb begin
        w_state_ext      = {STATE_W{1'b0}};
        w_state_ext[3:0] = r_state;
    end

    // Enables are held off for the whole reset pulse, not just until the next edge
    assign bus.PCWrite    = ~reset & (w_pc_update | (w_branch & bus.zero));
    assign bus.IRWrite    = ~reset & w_ir_write;
    assign bus.RegWrite   = ~reset & w_reg_write;
    assign bus.MemWrite   = ~reset & w_mem_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.AluControl = f_alu_control(w_alu_op, bus.funct3, bus.op[5], bus.funct7b5);
    assign bus.state      = w_state_ext;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// Self-checking bench for alu_ctrl_fsm: directed instructions then random ones,
// compared against an instruction-level reference model.
module tb_alu_ctrl_fsm;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   seq[$];
    logic [13:0] ctl_tbl [0:10];
    logic [6:0]  op_list [0:5];

    alu_ctrl_fsm_if #(.STATE_W(4)) bus();
    alu_ctrl_fsm #(.STATE_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_imm(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] exp_alu(input logic [1:0] aluop, input logic [6:0] o,
                                           input logic [2:0] f3, input logic f7);
        if (aluop == 2'b01) return 3'b001;
        if (aluop != 2'b10) return 3'b000;
        if (f3 == 3'b000) return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        return 3'b000;
    endfunction

    // Control word layout: ir adr memw regw res[2] srcA[2] srcB[2] aluop[2] pcupd branch
    task automatic check_cycle(input int st, input logic rst_v);
        logic [13:0] c;
        logic        pcw;
        c   = ctl_tbl[st];
        pcw = c[1] | (c[0] & bus.zero);
        chk($sformatf("st%0d.state", st), 32'(bus.state), 32'(st));
        chk($sformatf("st%0d.wen", st), 32'({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemWrite}),
            rst_v ? 32'd0 : 32'({pcw, c[13], c[10], c[11]}));
        chk($sformatf("st%0d.sel", st), 32'({bus.AdrSrc, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB}),
            32'({c[12], c[9:8], c[7:6], c[5:4]}));
        chk($sformatf("st%0d.imm", st), 32'(bus.ImmSrc), 32'(exp_imm(bus.op)));
        chk($sformatf("st%0d.aluctl", st), 32'(bus.AluControl),
            32'(exp_alu(c[3:2], bus.op, bus.funct3, bus.funct7b5)));
    endtask

    // zmode: 0/1 hold zero constant, 2 randomise it each cycle; abort_at: cycle index to pulse reset
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input int abort_at);
        bus.op       = o;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        seq = {0, 1};
        case (o)
            7'b0000011: seq = {seq, 2, 3, 4};
            7'b0100011: seq = {seq, 2, 5};
            7'b0110011: seq = {seq, 6, 8};
            7'b0010011: seq = {seq, 7, 8};
            7'b1100011: seq = {seq, 9};
            7'b1101111: seq = {seq, 10, 8};
            default:    seq = {seq};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check_cycle(0, 1'b1);
                @(negedge clk);
                check_cycle(0, 1'b1);
                reset = 1'b0;
                return;
            end
            #1;
            check_cycle(seq[i], 1'b0);
            @(negedge clk);
        end
    endtask

    initial begin
        ctl_tbl[0]  = {1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1, 1'b0};
        ctl_tbl[1]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
        ctl_tbl[2]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, 1'b0, 1'b0};
        ctl_tbl[3]  = {1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl_tbl[4]  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl_tbl[5]  = {1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl_tbl[6]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0};
        ctl_tbl[7]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, 1'b0, 1'b0};
        ctl_tbl[8]  = {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        ctl_tbl[9]  = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 1'b0, 1'b1};
        ctl_tbl[10] = {1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, 1'b1, 1'b0};
        op_list[0] = 7'b0000011;
        op_list[1] = 7'b0100011;
        op_list[2] = 7'b0110011;
        op_list[3] = 7'b0010011;
        op_list[4] = 7'b1100011;
        op_list[5] = 7'b1101111;

        bus.op       = 7'd0;
        bus.funct3   = 3'd0;
        bus.funct7b5 = 1'b0;
        bus.zero     = 1'b0;

        // Asynchronous reset with no clock edge in between
        #1 reset = 1'b1;
        #1 check_cycle(0, 1'b1);
        @(negedge clk);
        check_cycle(0, 1'b1);
        reset = 1'b0;

        run_instr(7'b0000011, 3'b010, 1'b0, 2, -1);   // lw
        run_instr(7'b0110011, 3'b000, 1'b1, 2, -1);   // sub
        run_instr(7'b0010011, 3'b000, 1'b1, 2, -1);   // addi, funct7b5 ignored
        run_instr(7'b0110011, 3'b010, 1'b0, 2, -1);   // slt
        run_instr(7'b0110011, 3'b110, 1'b0, 2, -1);   // or
        run_instr(7'b0110011, 3'b111, 1'b0, 2, -1);   // and
        run_instr(7'b0010011, 3'b100, 1'b0, 2, -1);   // unlisted funct3
        run_instr(7'b1100011, 3'b000, 1'b0, 1, -1);   // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 0, -1);   // beq not taken
        run_instr(7'b0100011, 3'b010, 1'b0, 2, -1);   // sw
        run_instr(7'b1101111, 3'b000, 1'b0, 2, -1);   // jal
        run_instr(7'b0000000, 3'b000, 1'b0, 2, -1);   // illegal opcode
        run_instr(7'b0000011, 3'b010, 1'b0, 2, 3);    // reset during MEMREAD
        run_instr(7'b0000011, 3'b010, 1'b0, 2, -1);   // clean lw after abort

        for (int k = 0; k < 60; k++) begin
            logic [6:0] o;
            int         pick;
            pick = int'($urandom_range(0, 6));
            o    = (pick == 6) ? 7'($urandom) : op_list[pick];
            run_instr(o, 3'($urandom), 1'($urandom), 2, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
